// File: rtl/sreg_bwd.sv
// Two-entry skid register: fully registered valid/ready/data on both sides.
// Latency is 1 cycle EMPTY->valid; the skid entry absorbs the one word that arrives as ready falls.
module sreg_bwd #(
   parameter int T_WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [T_WIDTH-1:0] s_port_data,
   input  logic               s_port_valid,
   output logic               s_port_ready,
   output logic [T_WIDTH-1:0] m_port_data,
   output logic               m_port_valid,
   input  logic               m_port_ready,
   output logic [1:0]         level
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_BUSY  = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t             r_state;
   logic [T_WIDTH-1:0] r_main;
   logic [T_WIDTH-1:0] r_skid;
   logic               r_m_valid;
   logic               r_s_ready;
   logic [1:0]         r_level;

   logic               w_s_xfer;
   logic               w_m_xfer;

   assign w_s_xfer = s_port_valid & r_s_ready;
   assign w_m_xfer = r_m_valid & m_port_ready;

   // Outputs are written alongside the state so they always match the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_EMPTY;
         r_main    <= '0;
         r_skid    <= '0;
         r_m_valid <= 1'b0;
         r_s_ready <= 1'b0;
         r_level   <= 2'd0;
      end else begin
         unique case (r_state)
            S_EMPTY: begin
               r_s_ready <= 1'b1;
               if (w_s_xfer) begin
                  r_main    <= s_port_data;
                  r_state   <= S_BUSY;
                  r_m_valid <= 1'b1;
                  r_level   <= 2'd1;
               end else begin
                  r_state   <= S_EMPTY;
                  r_m_valid <= 1'b0;
                  r_level   <= 2'd0;
               end
            end
            S_BUSY: begin
               if (w_s_xfer && !w_m_xfer) begin
                  r_skid    <= s_port_data;
                  r_state   <= S_FULL;
                  r_m_valid <= 1'b1;
                  r_s_ready <= 1'b0;
                  r_level   <= 2'd2;
               end else if (!w_s_xfer && w_m_xfer) begin
                  r_state   <= S_EMPTY;
                  r_m_valid <= 1'b0;
                  r_s_ready <= 1'b1;
                  r_level   <= 2'd0;
               end else begin
                  if (w_s_xfer) begin
                     r_main <= s_port_data;
                  end
                  r_state   <= S_BUSY;
                  r_m_valid <= 1'b1;
                  r_s_ready <= 1'b1;
                  r_level   <= 2'd1;
               end
            end
            S_FULL: begin
               if (w_m_xfer) begin
                  r_main    <= r_skid;
                  r_state   <= S_BUSY;
                  r_m_valid <= 1'b1;
                  r_s_ready <= 1'b1;
                  r_level   <= 2'd1;
               end else begin
                  r_state   <= S_FULL;
                  r_m_valid <= 1'b1;
                  r_s_ready <= 1'b0;
                  r_level   <= 2'd2;
               end
            end
            default: begin
               r_state   <= S_EMPTY;
               r_m_valid <= 1'b0;
               r_s_ready <= 1'b0;
               r_level   <= 2'd0;
            end
         endcase
      end
   end

   assign s_port_ready = r_s_ready;
   assign m_port_data  = r_main;
   assign m_port_valid = r_m_valid;
   assign level        = r_level;

endmodule

// File: tb/tb_sreg_bwd.sv
// Bench for sreg_bwd: directed sequences plus random traffic, checked by a queue-based model.
module tb_sreg_bwd;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] s_data = '0;
   logic         s_valid = 1'b0;
   logic         m_ready = 1'b0;
   logic         s_ready;
   logic         m_valid;
   logic [W-1:0] m_data;
   logic [1:0]   level;

   always #5 clk = ~clk;

   sreg_bwd #(.T_WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .s_port_data  (s_data),
      .s_port_valid (s_valid),
      .s_port_ready (s_ready),
      .m_port_data  (m_data),
      .m_port_valid (m_valid),
      .m_port_ready (m_ready),
      .level        (level)
   );

   int checks = 0;
   int passes = 0;
   int n_out  = 0;

   // Reference model: a FIFO of capacity two, ready whenever it is not full.
   logic [W-1:0] exp_q[$];
   int           occ      = 0;
   logic         rdy_exp  = 1'b0;
   logic         last_rst = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   always @(posedge clk) begin
      bit sx, mx;
      last_rst = reset;
      if (reset) begin
         exp_q.delete();
         occ     = 0;
         rdy_exp = 1'b0;
      end else begin
         sx = s_valid && rdy_exp;
         mx = (occ > 0) && m_ready;
         if (mx) occ--;
         if (sx) begin
            occ++;
            exp_q.push_back(s_data);
         end
         rdy_exp = (occ < 2);
      end
   end

   // Monitor: compares on the falling edge, pops a word whenever a downstream transfer is presented.
   logic         pv = 1'b0;
   logic         pr = 1'b0;
   logic [W-1:0] pd = '0;

   always @(negedge clk) begin
      chk("level", 32'(level), 32'(occ));
      chk("m_valid", 32'(m_valid), 32'(occ > 0));
      chk("s_ready", 32'(s_ready), 32'(rdy_exp));
      if (last_rst) begin
         chk("rst_data", 32'(m_data), 32'd0);
      end else if (pv && !pr) begin
         chk("hold_valid", 32'(m_valid), 32'd1);
         chk("hold_data", 32'(m_data), 32'(pd));
      end
      if (!reset && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
         end else begin
            chk("order_data", 32'(m_data), 32'(exp_q.pop_front()));
         end
         n_out++;
      end
      pv = m_valid;
      pr = m_ready;
      pd = m_data;
   end

   task automatic drive(input logic r, input logic v, input logic [W-1:0] d, input logic mr);
      @(posedge clk);
      #1;
      reset   = r;
      s_valid = v;
      s_data  = d;
      m_ready = mr;
   endtask

   initial begin
      int n0;
      int bias;
      repeat (3) drive(1'b1, 1'b0, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b1);

      // Single word
      drive(1'b0, 1'b1, 8'h5A, 1'b1);
      repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b1);

      // Streaming
      n0 = n_out;
      for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 8'(i), 1'b1);
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      chk("stream_count", 32'(n_out - n0), 32'd16);

      // Backpressure then drain
      drive(1'b0, 1'b1, 8'hA1, 1'b0);
      drive(1'b0, 1'b1, 8'hA2, 1'b0);
      drive(1'b0, 1'b1, 8'hA3, 1'b0);
      drive(1'b0, 1'b1, 8'hA3, 1'b0);
      @(negedge clk);
      chk("bp_data", 32'(m_data), 32'hA1);
      chk("bp_level", 32'(level), 32'd2);
      chk("bp_ready", 32'(s_ready), 32'd0);
      drive(1'b0, 1'b1, 8'hA3, 1'b1);
      drive(1'b0, 1'b1, 8'hA3, 1'b1);
      repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b1);

      // Reset while full
      drive(1'b0, 1'b1, 8'hB1, 1'b0);
      drive(1'b0, 1'b1, 8'hB2, 1'b0);
      drive(1'b1, 1'b0, 8'h00, 1'b1);
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      @(negedge clk);
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_ready", 32'(s_ready), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      n0 = n_out;
      drive(1'b0, 1'b1, 8'h33, 1'b1);
      repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b1);
      chk("post_rst_count", 32'(n_out - n0), 32'd1);

      // Random traffic with a downstream-ready bias that shifts every 500 cycles
      bias = 2;
      for (int i = 0; i < 10000; i++) begin
         if (i % 500 == 0) bias = int'($urandom_range(0, 4));
         drive(($urandom_range(0, 999) == 0),
               1'($urandom_range(0, 1)),
               8'($urandom),
               ($urandom_range(0, 3) < bias));
      end
      repeat (5) drive(1'b0, 1'b0, 8'h00, 1'b1);
      @(negedge clk);
      chk("final_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
